// File: rtl/sec_display_pkg.sv
// Shared definitions for the seconds display: conversion FSM states,
// active-low seven-segment patterns and conversion constants.
`timescale 1ns/1ps
package sec_display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DIV    = 3'd2,
    ST_BCD    = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, a zero lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Largest value shown as MM:SS (99:59).
  localparam logic [15:0] SAT_LIMIT   = 16'd5999;
  localparam logic [12:0] SEC_PER_MIN = 13'd60;
  localparam int          BCD_W       = 4;
  // Double-dabble over a 7-bit binary operand takes one shift per bit.
  localparam int          DD_STEPS    = 7;
  localparam logic [2:0]  DD_LAST     = 3'(DD_STEPS - 1);

  // Double-dabble correction: a BCD digit of 5 or more gets 3 added
  // before the shift so it carries correctly into the next digit.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] d);
    if (d >= 4'd5) return d + 4'd3;
    else           return d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment decoder with a blank override.
// Codes above 9 decode to all segments off.
`timescale 1ns/1ps
module seg7_decode
  import sec_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pure lookup; blank wins over any digit code.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sec_display.sv
// Seconds-to-MM.SS display stage. Converts the timer's elapsed-seconds
// count to minutes/seconds (saturating at 99:59) with a multi-cycle
// subtract-and-count divider plus double-dabble, then scans the four
// digits onto a multiplexed active-low seven-segment display.
// Optional build macro SEC_DISPLAY_LZB_EN enables leading-zero blanking
// of the minutes tens digit.
`timescale 1ns/1ps
module sec_display
  import sec_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sec,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        ovf
);

  localparam int             CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       last_sec;
  logic [12:0]       rem;
  logic [6:0]        min_cnt;
  logic              ovf_nxt;
  // Layout {tens[14:11], units[10:7], binary[6:0]}
  logic [14:0]       dd_min;
  logic [14:0]       dd_rem;
  logic [2:0]        dd_cnt;
  logic [3:0][3:0]   digits;
  logic [CNT_W-1:0]  refresh_cnt;
  logic [1:0]        sel;

  logic              load_en;
  logic              div_step;
  logic              dd_init;
  logic              dd_step_en;
  logic              commit_en;
  logic              rem_ge_min;

  logic [3:0]        digit_p0;
  logic              blank_p0;
  logic [6:0]        seg_dec_p0;

  // Clamp the input to the largest displayable value.
  function automatic logic [12:0] sat_sec(input logic [15:0] v);
    if (v > SAT_LIMIT) return SAT_LIMIT[12:0];
    else               return v[12:0];
  endfunction

  // One double-dabble iteration: correct both BCD digits, then shift left.
  function automatic logic [14:0] dd_shift(input logic [14:0] v);
    logic [14:0] a;
    a         = v;
    a[14:11]  = bcd_adjust(v[14:11]);
    a[10:7]   = bcd_adjust(v[10:7]);
    return a << 1;
  endfunction

  assign rem_ge_min = (rem >= SEC_PER_MIN);

  // Conversion FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Conversion FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (sec != last_sec) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_DIV;
      ST_DIV:    if (!rem_ge_min) state_nxt = ST_BCD;
      ST_BCD:    if (dd_cnt == DD_LAST) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Conversion FSM datapath strobes.
  always_comb begin
    load_en    = 1'b0;
    div_step   = 1'b0;
    dd_init    = 1'b0;
    dd_step_en = 1'b0;
    commit_en  = 1'b0;
    case (state)
      ST_LOAD:   load_en = 1'b1;
      ST_DIV: begin
        if (rem_ge_min) div_step = 1'b1;
        else            dd_init  = 1'b1;
      end
      ST_BCD:    dd_step_en = 1'b1;
      ST_COMMIT: commit_en  = 1'b1;
      default: ;
    endcase
  end

  // Remember the last captured input so only real changes start a conversion;
  // the all-ones reset value forces a conversion after reset.
  always_ff @(posedge clk) begin
    if (rst)          last_sec <= 16'hFFFF;
    else if (load_en) last_sec <= sec;
  end

  // Divider and double-dabble working registers; always re-seeded before use.
  always_ff @(posedge clk) begin
    if (load_en) begin
      rem     <= sat_sec(sec);
      min_cnt <= 7'd0;
      ovf_nxt <= (sec > SAT_LIMIT);
    end
    if (div_step) begin
      rem     <= rem - SEC_PER_MIN;
      min_cnt <= min_cnt + 7'd1;
    end
    if (dd_init) begin
      dd_min <= {8'd0, min_cnt};
      dd_rem <= {8'd0, rem[6:0]};
      dd_cnt <= 3'd0;
    end
    if (dd_step_en) begin
      dd_min <= dd_shift(dd_min);
      dd_rem <= dd_shift(dd_rem);
      dd_cnt <= dd_cnt + 3'd1;
    end
  end

  // All four digits and the overflow flag update together on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits <= '0;
      ovf    <= 1'b0;
    end else if (commit_en) begin
      digits[0] <= dd_rem[10:7];
      digits[1] <= dd_rem[14:11];
      digits[2] <= dd_min[10:7];
      digits[3] <= dd_min[14:11];
      ovf       <= ovf_nxt;
    end
  end

  // Free-running refresh divider; each wrap advances the scanned digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      sel         <= 2'd0;
    end else if (refresh_cnt == CNT_MAX) begin
      refresh_cnt <= '0;
      sel         <= sel + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  // Select the scanned digit and decide whether it is blanked.
  always_comb begin
    digit_p0 = digits[sel];
`ifdef SEC_DISPLAY_LZB_EN
    blank_p0 = (sel == 2'd3) && (digits[3] == 4'd0);
`else
    blank_p0 = 1'b0;
`endif
  end

  seg7_decode u_seg7_decode (
    .bcd   (digit_p0),
    .blank (blank_p0),
    .seg   (seg_dec_p0)
  );

  // Registered display outputs, one cycle behind the digit select.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << sel);
      seg <= seg_dec_p0;
      dp  <= (sel != 2'd2);
    end
  end

endmodule

// File: tb/tb_sec_display.sv
// Scoreboard bench for sec_display with REFRESH_DIV = 4. Stimulus pushes the
// expected display frame; a monitor captures one full scan frame and compares.
`timescale 1ns/1ps
module tb_sec_display;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sec = 16'd0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        ovf;

  sec_display #(.REFRESH_DIV(RD)) dut (
    .clk (clk),
    .rst (rst),
    .sec (sec),
    .an  (an),
    .seg (seg),
    .dp  (dp),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][6:0] segs;
    logic            ovf;
    int              id;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  logic track = 1'b0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected pattern for the minutes tens digit.
  function automatic logic [6:0] seg_d3(input int d);
`ifdef SEC_DISPLAY_LZB_EN
    if (d == 0) return 7'b1111111;
`endif
    return seg_of(d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_frame(input int d3, input int d2, input int d1, input int d0,
                            input logic o, input int id);
    exp_t e;
    e.segs[3] = seg_d3(d3);
    e.segs[2] = seg_of(d2);
    e.segs[1] = seg_of(d1);
    e.segs[0] = seg_of(d0);
    e.ovf     = o;
    e.id      = id;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sbq.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    #1;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d frames still pending, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic run_case(input logic [15:0] v, input int wait_cyc,
                          input int d3, input int d2, input int d1, input int d0,
                          input logic o, input int id);
    sec = v;
    repeat (wait_cyc) @(posedge clk);
    #1;
    push_frame(d3, d2, d1, d0, o, id);
    drain();
  endtask

  // Monitor: capture one full frame starting at the first cycle of digit 0.
  initial begin : monitor
    exp_t       e;
    int         guard;
    int         d;
    logic [3:0] ea;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e     = sbq[0];
        guard = 0;
        while (an == 4'b1110 && guard < 64) begin @(negedge clk); guard++; end
        while (an != 4'b1110 && guard < 64) begin @(negedge clk); guard++; end
        if (guard >= 64) begin
          total++;
          bad++;
          $display("FAIL f%0d_sync: an=%b, expected 1110 within 64 cycles", e.id, an);
        end else begin
          for (int k = 0; k < 4 * RD; k++) begin
            d  = k / RD;
            ea = ~(4'b0001 << d);
            check($sformatf("f%0d_an_k%0d", e.id, k), 32'(an), 32'(ea));
            check($sformatf("f%0d_seg_d%0d", e.id, d), 32'(seg), 32'(e.segs[d]));
            check($sformatf("f%0d_dp_d%0d", e.id, d), 32'(dp), (d == 2) ? 32'd0 : 32'd1);
            if (k == 0) check($sformatf("f%0d_ovf", e.id), 32'(ovf), 32'(e.ovf));
            @(negedge clk);
          end
        end
        void'(sbq.pop_front());
      end
    end
  end

  // While a mid-conversion change is in flight only 00.00, 00.59 and 01.00
  // digits may ever appear.
  always @(negedge clk) begin
    if (track) begin
      total++;
      case (an)
        4'b1110: if (!(seg === seg_of(0) || seg === seg_of(9))) begin
          bad++; $display("FAIL mid_d0: seg=%b expected 0 or 9 pattern", seg);
        end
        4'b1101: if (!(seg === seg_of(0) || seg === seg_of(5))) begin
          bad++; $display("FAIL mid_d1: seg=%b expected 0 or 5 pattern", seg);
        end
        4'b1011: if (!(seg === seg_of(0) || seg === seg_of(1))) begin
          bad++; $display("FAIL mid_d2: seg=%b expected 0 or 1 pattern", seg);
        end
        4'b0111: if (seg !== seg_d3(0)) begin
          bad++; $display("FAIL mid_d3: seg=%b expected %b", seg, seg_d3(0));
        end
        default: begin
          bad++; $display("FAIL mid_an: an=%b expected one zero bit", an);
        end
      endcase
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1;
    sec = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    // First cycle after release still shows the reset values.
    check("rst_an",  32'(an),  32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp",  32'(dp),  32'd1);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    check("first_scan_an", 32'(an), 32'hE);
    repeat (14) @(posedge clk);
    #1;
    push_frame(0, 0, 0, 0, 1'b0, 0);
    drain();

    run_case(16'd125,   16,  0, 2, 0, 5, 1'b0, 1);
    run_case(16'd5999,  113, 9, 9, 5, 9, 1'b0, 2);
    run_case(16'd6000,  113, 9, 9, 5, 9, 1'b1, 3);
    run_case(16'd65535, 113, 9, 9, 5, 9, 1'b1, 4);

    // Reset pulse while the 3000 conversion is in its divide loop.
    sec = 16'd3000;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_an",  32'(an),  32'hF);
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_dp",  32'(dp),  32'd1);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    run_case(16'd3000, 64, 5, 0, 0, 0, 1'b0, 5);

    run_case(16'd0, 14, 0, 0, 0, 0, 1'b0, 6);

    // Input changes three cycles into a conversion.
    track = 1'b1;
    sec   = 16'd59;
    repeat (3) @(posedge clk);
    #1;
    sec = 16'd60;
    repeat (40) @(posedge clk);
    #1;
    track = 1'b0;
    run_case(16'd60, 2, 0, 1, 0, 0, 1'b0, 7);

    // 65 s = 01.05; minutes tens is zero, exercising the blanking option.
    run_case(16'd65, 15, 0, 1, 0, 5, 1'b0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sec_display.md
# sec_display

Downstream display stage for the seconds timer. It consumes the timer's 16-bit elapsed-seconds count and converts it to minutes and seconds, saturating at 99:59. It drives a 4-digit multiplexed, active-low seven-segment display as MM.SS. Conversion is iterative and multi-cycle, and the display refresh runs independently from a free-running divider.

## Interface
- `REFRESH_DIV`, default 50_000: clock cycles each digit stays enabled (1 ms at 50 MHz); legal ≥ 2.
- `clk`  in  1: system clock, same domain as the timer.
- `rst`  in  1: synchronous, active-high reset.
- `sec`  in  16: elapsed seconds from the timer, unsigned.
- `an`  out  4: digit enables, active low. `an[0]` = seconds units … `an[3]` = minutes tens.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active low.
- `dp`  out  1: decimal point, active low. Lit only on digit 2 (separator).
- `ovf`  out  1: high while the displayed value is saturated (`sec` ≥ 6000 at last capture).

## Operation
- Conversion FSM states: IDLE, LOAD, DIV, BCD, COMMIT.
- **IDLE:** if `sec` ≠ `last_sec`, go to LOAD. After reset, `last_sec` holds 16'hFFFF, so the first conversion is forced.
- **LOAD:**
  - Capture `sec` into `last_sec`.
  - If the value is ≥ 6000, use 5999 and set `ovf_nxt` = 1; otherwise `ovf_nxt` = 0.
  - Set `rem` = value, `min` = 0.
- **DIV:** each cycle, if `rem` ≥ 60 then `rem` −= 60 and `min` += 1; otherwise go to BCD. `min` is 7-bit (0..99); `rem` ends in 0..59.
- **BCD:** double-dabble `min` and `rem` in parallel, 7 shift cycles, producing two BCD digits each.
- **COMMIT:** load all four display digits and `ovf` in the same cycle, then return to IDLE. The display never shows a partially converted value.
- **`sec` changes mid-conversion:** the change is ignored until IDLE. It is then detected against `last_sec` and converted. Intermediate values may be skipped; the final value is always displayed.
- **Scan:**
  - A refresh counter counts 0..REFRESH_DIV−1.
  - On wrap, the digit select advances 0→1→2→3→0.
  - `an` has exactly one zero bit, for the selected digit.
  - `seg` shows that digit's BCD decode. Codes 0–9 use the standard active-low patterns (0 = 1000000, 1 = 1111001, 8 = 0000000); codes > 9 and blank produce 1111111.
- **Reset (any state, including mid-conversion):** FSM → IDLE; refresh counter and digit select → 0; display digits → 0; `ovf` → 0; `an` = 1111, `seg` = 1111111, `dp` = 1.

## Timing
- `an`/`seg`/`dp` are registered, with 1-cycle latency from the digit select.
- The first cycle after reset release still shows all off. From the second cycle, digit 0 is enabled.
- Conversion latency from the IDLE cycle that detects a change to the new digits appearing on the registered outputs: 1 (LOAD) + M + 1 (DIV, where M = resulting minutes) + 7 (BCD) + 1 (COMMIT) + 1 (output register) = M + 11 cycles. Worst case is 110 cycles (M = 99), far below one second at 50 MHz.
- Each digit is enabled for exactly REFRESH_DIV cycles; full frame = 4·REFRESH_DIV.
- `ovf` changes in the COMMIT cycle.

## Configuration
- Macro: `SEC_DISPLAY_LZB_EN`.
- **Defined:** leading-zero blanking. When the minutes tens digit is 0, digit 3 shows blank (`seg` = 1111111, `an` still scanned). Digits 0–2 are always shown.
- **Undefined:** all four digits are always shown, e.g. "00.05".

## Structure
- Package `sec_display_pkg`:
  - FSM state enum.
  - Segment constants: digits 0–9 and BLANK.
  - Saturation limit 5999.
  - Constant 60 and BCD width.
- Sub-module `seg7_decode`: combinational, 4-bit BCD plus a blank flag in, 7-bit active-low segments out. It is shared with future display blocks.
- The FSM, refresh counter and output registers live in the top module.

## Test plan
Simulate with REFRESH_DIV = 4.
- **Reset:** assert `rst` 3 cycles with `sec` = 0 → `an` = 1111, `seg` = 1111111, `dp` = 1, `ovf` = 0. After release and conversion, the scan shows digits 0,0,0,0 with `dp` low only while `an` = 1011.
- **Basic conversion:** `sec` = 125 → after 13 cycles, digits read 0,2,0,5 (M = 2). Digit 0 `seg` = 0010010 ("5"); digit 1 `seg` = 1000000.
- **Maximum in range:** `sec` = 5999 → "99.59" after 110 cycles, `ovf` = 0.
- **Saturation:** `sec` = 6000, then `sec` = 65535 → "99.59" with `ovf` = 1 in both cases. `sec` = 0 afterwards → "00.00", `ovf` = 0.
- **Change mid-conversion:** `sec` = 59, then `sec` = 60 three cycles later → commit "00.59", then "01.00". No other values appear.
- **Reset mid-DIV and blanking:**
  - `sec` = 3000; pulse `rst` during DIV → outputs return to the reset values, then conversion restarts and shows "50.00".
  - With `SEC_DISPLAY_LZB_EN`, `sec` = 65 → digit 3 `seg` = 1111111. Without it, digit 3 `seg` = 1000000.
